// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared types and helpers for the SRAM arbiter
// Purpose: FSM state encoding, write-strobe constants and the byte-lane merge
//          used to build read-modify-write data.
// Ports:   none (package).
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2,
    ST_WR   = 2'd3
  } state_e;

  localparam logic [3:0] WSTRB_FULL = 4'hF;
  localparam logic [3:0] WSTRB_READ = 4'h0;

  // Strobed lanes take the new write data, the rest keep the word read from the macro.
  function automatic logic [31:0] merge_lanes(input logic [31:0] new_d,
                                               input logic [31:0] old_d,
                                               input logic [3:0]  strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = strb[i] ? new_d[i*8 +: 8] : old_d[i*8 +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - picorv32-style requester port bundle
// Purpose: one requester's valid/ready handshake plus address, strobes and data.
// Ports:   valid/addr/wstrb/wdata driven by the master (requester),
//          ready/rdata driven by the slave (arbiter).
interface sram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, addr, wstrb, wdata, input  ready, rdata);
  modport slave  (input  valid, addr, wstrb, wdata, output ready, rdata);
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with optional fixed priority
// Purpose: picks one of two requesters; the pointer moves to the other port
//          after every accepted grant. FIXED_PRIO=1 makes port 0 always win.
// Ports:   clk, reset (sync, active-high); req[1:0] requests; advance commits
//          the current grant; gnt[1:0] one-hot grant (zero when no request).
module rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (FIXED_PRIO != 0) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      // Only a tie needs the pointer; a lone request always wins.
      if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
      else              gnt = req;
    end
    ptr_d = ptr_q;
    if (advance && (gnt != 2'b00)) ptr_d = gnt[0];
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one single-port 1024x32 SRAM between two requesters
// Purpose: arbitrates port 0 (CPU) and port 1 (DMA/loader) onto the macro;
//          byte-strobed writes are done as read-modify-write.
// Ports:   clk, reset (sync, active-high); p0, p1 requester bundles;
//          sram_a/sram_d/sram_cen/sram_wen/sram_oen to the macro, sram_q from it.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  sram_arbiter_if.slave     p0,
  sram_arbiter_if.slave     p1,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic              sram_oen,
  input  logic [DATA_W-1:0] sram_q
);
  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;     // granted port index
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d;   // write data, merged with Q on partial writes
  logic [1:0]        req, gnt;
  logic              advance, done;

  assign req     = {p1.valid, p0.valid};
  assign advance = (state_q == ST_IDLE) && (req != 2'b00);

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .gnt     (gnt)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wbuf_d  = wbuf_q;
    case (state_q)
      ST_IDLE: begin
        if (advance) begin
          gnt_d   = gnt[1];
          addr_d  = gnt[1] ? p1.addr  : p0.addr;
          wstrb_d = gnt[1] ? p1.wstrb : p0.wstrb;
          wbuf_d  = gnt[1] ? p1.wdata : p0.wdata;
          state_d = (wstrb_d == WSTRB_FULL) ? ST_WR : ST_RD;
        end
      end
      ST_RD:  state_d = ST_CAP;
      ST_CAP: begin
        if (wstrb_q == WSTRB_READ) begin
          state_d = ST_IDLE;
        end else begin
          wbuf_d  = merge_lanes(wbuf_q, sram_q, wstrb_q);
          state_d = ST_WR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wbuf_q  <= wbuf_d;
    end
  end

  // Macro controls come from the state register alone. CEn stays low through
  // CAP because raising it would clear Q before it is consumed.
  assign sram_cen = (state_q == ST_IDLE);
  assign sram_oen = (state_q != ST_RD);
  assign sram_wen = (state_q != ST_WR);
  assign sram_a   = addr_q;
  assign sram_d   = wbuf_q;

  assign done     = ((state_q == ST_CAP) && (wstrb_q == WSTRB_READ)) || (state_q == ST_WR);
  assign p0.ready = done && !gnt_q;
  assign p1.ready = done &&  gnt_q;
  assign p0.rdata = sram_q;
  assign p1.rdata = sram_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(10), .DATA_W(32)) p0 ();
  sram_arbiter_if #(.ADDR_W(10), .DATA_W(32)) p1 ();
  sram_arbiter_if #(.ADDR_W(10), .DATA_W(32)) f0 ();
  sram_arbiter_if #(.ADDR_W(10), .DATA_W(32)) f1 ();

  logic [9:0]  sram_a, f_a;
  logic [31:0] sram_d, sram_q, f_d;
  logic        sram_cen, sram_wen, sram_oen, f_cen, f_wen, f_oen;
  logic [31:0] f_q = 32'h0;

  sram_arbiter #(.ADDR_W(10), .DATA_W(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset), .p0(p0), .p1(p1),
    .sram_a(sram_a), .sram_d(sram_d), .sram_cen(sram_cen),
    .sram_wen(sram_wen), .sram_oen(sram_oen), .sram_q(sram_q)
  );

  sram_arbiter #(.ADDR_W(10), .DATA_W(32), .FIXED_PRIO(1)) dut_fixed (
    .clk(clk), .reset(reset), .p0(f0), .p1(f1),
    .sram_a(f_a), .sram_d(f_d), .sram_cen(f_cen),
    .sram_wen(f_wen), .sram_oen(f_oen), .sram_q(f_q)
  );

  // Macro model: Q registered, loaded when OEn=0, cleared while CEn is high.
  logic [31:0] mem [0:1023];
  logic [31:0] q_r = 32'h0;
  assign sram_q = q_r;
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (sram_cen) q_r <= 32'h0;
    else begin
      if (!sram_wen) mem[sram_a] <= sram_d;
      if (!sram_oen) q_r <= mem[sram_a];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and measure edges until its ready pulse.
  task automatic txn(input int port, input logic [9:0] addr, input logic [3:0] strb,
                     input logic [31:0] data, input int exp_lat,
                     input logic chk_rd, input logic [31:0] exp_rd, input string tag);
    int lat = 0;
    logic got = 1'b0;
    logic [31:0] rd = 32'h0;
    if (port == 0) begin
      p0.valid = 1'b1; p0.addr = addr; p0.wstrb = strb; p0.wdata = data;
    end else begin
      p1.valid = 1'b1; p1.addr = addr; p1.wstrb = strb; p1.wdata = data;
    end
    while (!got && lat < 20) begin
      tick();
      lat++;
      if (port == 0 && p0.ready) begin got = 1'b1; rd = p0.rdata; end
      if (port == 1 && p1.ready) begin got = 1'b1; rd = p1.rdata; end
    end
    check({tag, "_latency"}, lat, exp_lat);
    if (chk_rd) check({tag, "_rdata"}, rd, exp_rd);
    p0.valid = 1'b0;
    p1.valid = 1'b0;
    tick();
  endtask

  int order [4];
  int n;
  int cyc;

  initial begin
    p0.valid = 0; p0.addr = '0; p0.wstrb = '0; p0.wdata = '0;
    p1.valid = 0; p1.addr = '0; p1.wstrb = '0; p1.wdata = '0;
    f0.valid = 0; f0.addr = '0; f0.wstrb = '0; f0.wdata = '0;
    f1.valid = 0; f1.addr = '0; f1.wstrb = '0; f1.wdata = '0;
    reset = 1'b1;
    repeat (3) tick();
    check("reset_p0_ready", {31'b0, p0.ready}, 32'd0);
    check("reset_p1_ready", {31'b0, p1.ready}, 32'd0);
    check("reset_cen", {31'b0, sram_cen}, 32'd1);
    check("reset_wen", {31'b0, sram_wen}, 32'd1);
    check("reset_oen", {31'b0, sram_oen}, 32'd1);
    reset = 1'b0;
    tick();

    // Full write then readback.
    txn(0, 10'h005, 4'hF, 32'hDEADBEEF, 1, 1'b0, 32'h0, "full_wr");
    check("full_wr_mem", mem[10'h005], 32'hDEADBEEF);
    txn(0, 10'h005, 4'h0, 32'h0, 2, 1'b1, 32'hDEADBEEF, "full_rd");

    // Partial write: lanes 0 and 2 replaced.
    txn(0, 10'h010, 4'hF, 32'h11223344, 1, 1'b0, 32'h0, "pre_wr");
    txn(1, 10'h010, 4'b0101, 32'hAABBCCDD, 3, 1'b0, 32'h0, "part_wr");
    check("part_wr_mem", mem[10'h010], 32'h11BB33DD);
    txn(1, 10'h010, 4'h0, 32'h0, 2, 1'b1, 32'h11BB33DD, "part_rd");

    // Contention: both ports hold valid; round-robin must alternate from port 0.
    p0.valid = 1; p0.addr = 10'h005; p0.wstrb = 4'h0;
    p1.valid = 1; p1.addr = 10'h010; p1.wstrb = 4'h0;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (p0.ready && p1.ready) check("rr_both_ready", 32'd1, 32'd0);
      if (p0.ready) begin
        check("rr_p0_rdata", p0.rdata, 32'hDEADBEEF);
        order[n] = 0; n++;
      end else if (p1.ready) begin
        check("rr_p1_rdata", p1.rdata, 32'h11BB33DD);
        order[n] = 1; n++;
      end
    end
    p0.valid = 0; p1.valid = 0;
    check("rr_grant_count", n, 4);
    if (n == 4) begin
      check("rr_order0", order[0], 0);
      check("rr_order1", order[1], 1);
      check("rr_order2", order[2], 0);
      check("rr_order3", order[3], 1);
    end
    tick();

    // CEn must stay low through RD and CAP on a read of the top word.
    txn(0, 10'h3FF, 4'hF, 32'hCAFEF00D, 1, 1'b0, 32'h0, "top_wr");
    p0.valid = 1; p0.addr = 10'h3FF; p0.wstrb = 4'h0;
    tick();
    check("cen_rd_cen", {31'b0, sram_cen}, 32'd0);
    check("cen_rd_oen", {31'b0, sram_oen}, 32'd0);
    check("cen_rd_a", {22'b0, sram_a}, 32'h3FF);
    tick();
    check("cen_cap_cen", {31'b0, sram_cen}, 32'd0);
    check("cen_cap_ready", {31'b0, p0.ready}, 32'd1);
    check("cen_cap_rdata", p0.rdata, 32'hCAFEF00D);
    p0.valid = 0;
    tick();
    check("cen_idle_cen", {31'b0, sram_cen}, 32'd1);

    // Reset during CAP of a partial write leaves memory untouched.
    txn(0, 10'h020, 4'hF, 32'h55667788, 1, 1'b0, 32'h0, "mid_pre_wr");
    p0.valid = 1; p0.addr = 10'h020; p0.wstrb = 4'b0011; p0.wdata = 32'h99AABBCC;
    tick();
    check("mid_rd_oen", {31'b0, sram_oen}, 32'd0);
    tick();
    check("mid_cap_ready", {31'b0, p0.ready}, 32'd0);
    check("mid_cap_cen", {31'b0, sram_cen}, 32'd0);
    reset = 1'b1;
    p0.valid = 0;
    tick();
    check("mid_rst_cen", {31'b0, sram_cen}, 32'd1);
    check("mid_rst_wen", {31'b0, sram_wen}, 32'd1);
    check("mid_rst_ready", {31'b0, p0.ready}, 32'd0);
    reset = 1'b0;
    tick();
    check("mid_mem", mem[10'h020], 32'h55667788);
    txn(0, 10'h020, 4'h0, 32'h0, 2, 1'b1, 32'h55667788, "mid_rd");

    // Fresh read after reset release.
    txn(0, 10'h000, 4'h0, 32'h0, 2, 1'b1, 32'h00000000, "rel_rd");

    // Fixed priority: port 0 wins every arbitration while it stays valid.
    f0.valid = 1; f0.addr = 10'h001; f0.wstrb = 4'h0;
    f1.valid = 1; f1.addr = 10'h002; f1.wstrb = 4'h0;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (f1.ready) check("fix_p1_ready", 32'd1, 32'd0);
      if (f0.ready) n++;
    end
    check("fix_p0_grants", n, 4);
    f0.valid = 0; f1.valid = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
